// File: rtl/commit_pkg.sv
// Shared types and default sizing for the operand commit controller.
package commit_pkg;

  localparam int RES_W_DEF   = 16;
  localparam int CNT_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 64;

  // Controller sequence: wait for new operands, launch, wait for result, hand off.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    PRESENT = 2'd3
  } state_t;

endpackage

// File: rtl/cycle_watchdog.sv
// Cycle counter that flags the last permitted cycle of a bounded wait.
module cycle_watchdog
  import commit_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [7:0] count;

  // Count enabled cycles; clear restarts the window before each wait.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // Terminal count: the current cycle is the last one the wait may last.
  always_comb begin
    tc = (count == 8'(TIMEOUT - 1));
  end

endmodule

// File: rtl/operand_commit_ctrl.sv
// Locks the capture stage, runs the compute unit under a watchdog and
// presents the result downstream over valid/ready.
module operand_commit_ctrl
  import commit_pkg::*;
#(
  parameter int RES_W   = RES_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             changed,
  output logic             locked,
  output logic             start,
  input  logic             done,
  input  logic [RES_W-1:0] result,
  output logic [RES_W-1:0] res_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             timeout_err,
  output logic             busy,
  output logic [CNT_W-1:0] res_cnt
);

  state_t state;
  state_t next_state;
  logic   next_timeout;
  logic   wd_tc;
  logic   capture;
  logic   accept;

  cycle_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == LAUNCH),
    .enable (state == WAIT),
    .tc     (wd_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; done beats the watchdog when both arrive together.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    next_state   = state;
    next_timeout = 1'b0;
    unique case (state)
      IDLE:    if (changed) next_state = LAUNCH;
      LAUNCH:  next_state = WAIT;
      WAIT: begin
        if (done) begin
          next_state = PRESENT;
        end else if (wd_tc) begin
          next_state   = IDLE;
          next_timeout = 1'b1;
        end
      end
      PRESENT: if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign capture = (state == WAIT) && done;
  assign accept  = (state == PRESENT) && res_ready;

  // Output registers, decoded from the next state so they track it without a gap.
  always_ff @(posedge clk) begin
    // NOTE: the result holding register is reset too, so res_out is defined from reset.
    if (rst) begin
      locked      <= 1'b0;
      start       <= 1'b0;
      res_valid   <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      res_out     <= '0;
      res_cnt     <= '0;
    end else begin
      locked      <= (next_state != IDLE);
      start       <= (next_state == LAUNCH);
      res_valid   <= (next_state == PRESENT);
      timeout_err <= next_timeout;
      busy        <= (next_state != IDLE);
      if (capture) res_out <= result;
      if (accept)  res_cnt <= res_cnt + CNT_W'(1);
    end
  end

endmodule
